// File: rtl/trb_in_demux.sv
// Input-side turbo frame distributor: dispatches whole fixed-length frames round-robin
// to decoder lanes and flags sop/eop framing violations. Optional per-lane frame
// counters are enabled by defining TRB_IN_DEMUX_CNT_EN.
module trb_in_demux #(
    parameter int NUM_TURBO = 8,
    parameter int FRAME_LEN = 128,
    parameter int CNT_W     = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             st_data_in,
    input  logic                   st_valid_in,
    input  logic                   st_sop_in,
    input  logic                   st_eop_in,
    output logic                   st_ready_out,
    output logic [NUM_TURBO*8-1:0] st_data_out,
    output logic [NUM_TURBO-1:0]   st_valid_out,
    output logic [NUM_TURBO-1:0]   st_sop_out,
    output logic [NUM_TURBO-1:0]   st_eop_out,
    input  logic [NUM_TURBO-1:0]   st_ready_in,
    output logic                   err_len,
    output logic                   err_sop
`ifdef TRB_IN_DEMUX_CNT_EN
    ,
    output logic [NUM_TURBO*16-1:0] frame_cnt
`endif
);

    localparam int PTR_W = (NUM_TURBO > 1) ? $clog2(NUM_TURBO) : 1;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_TURBO - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        S_HUNT = 1'b0,
        S_PASS = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_len_q, err_len_d;
    logic             err_sop_q, err_sop_d;

    logic pass_s, ready_s, accept_s, first_s, last_s, drop_s, fire_s, end_s;

    function automatic logic [PTR_W-1:0] next_lane(input logic [PTR_W-1:0] lane);
        logic [PTR_W-1:0] nxt;
        if (lane == LAST_LANE) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = lane + PTR_W'(1'b1);
        end
        return nxt;
    endfunction

    // Beat qualification: a beat at count 0 without sop is swallowed rather than forwarded.
    always_comb begin
        pass_s   = (state_q == S_PASS);
        ready_s  = pass_s & st_ready_in[sel_q];
        accept_s = st_valid_in & ready_s;
        first_s  = (cnt_q == {CNT_W{1'b0}});
        last_s   = (cnt_q == LAST_BEAT);
        drop_s   = first_s & ~st_sop_in;
        fire_s   = accept_s & ~drop_s;
        end_s    = fire_s & (last_s | st_eop_in);
    end

    // Next-state logic: HUNT probes one lane per cycle, PASS holds the lane until frame end.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_HUNT: begin
                if (st_ready_in[ptr_q]) begin
                    sel_d   = ptr_q;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_PASS;
                end else begin
                    ptr_d = next_lane(ptr_q);
                end
            end
            S_PASS: begin
                if (end_s) begin
                    ptr_d   = next_lane(sel_q);
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_HUNT;
                end else if (fire_s) begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_HUNT;
                ptr_d   = {PTR_W{1'b0}};
                sel_d   = {PTR_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Framing checks; both flags are registered so they pulse the cycle after the beat.
    always_comb begin
        err_sop_d = accept_s & (first_s ^ st_sop_in);
        err_len_d = fire_s & (last_s ^ st_eop_in);
    end

    // State and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HUNT;
            ptr_q     <= {PTR_W{1'b0}};
            sel_q     <= {PTR_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            err_len_q <= 1'b0;
            err_sop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            err_len_q <= err_len_d;
            err_sop_q <= err_sop_d;
        end
    end

    // Zero-latency lane fan-out: only the selected lane sees data while in PASS.
    always_comb begin
        st_data_out  = {(NUM_TURBO*8){1'b0}};
        st_valid_out = {NUM_TURBO{1'b0}};
        st_sop_out   = {NUM_TURBO{1'b0}};
        st_eop_out   = {NUM_TURBO{1'b0}};
        for (int i = 0; i < NUM_TURBO; i++) begin
            if (pass_s && (sel_q == PTR_W'(i))) begin
                st_data_out[8*i +: 8] = st_data_in;
                st_valid_out[i]       = fire_s;
                st_sop_out[i]         = fire_s & first_s;
                st_eop_out[i]         = end_s;
            end else begin
                st_data_out[8*i +: 8] = 8'd0;
                st_valid_out[i]       = 1'b0;
                st_sop_out[i]         = 1'b0;
                st_eop_out[i]         = 1'b0;
            end
        end
    end

    assign st_ready_out = ready_s;
    assign err_len      = err_len_q;
    assign err_sop      = err_sop_q;

`ifdef TRB_IN_DEMUX_CNT_EN
    logic [15:0] fcnt_q [NUM_TURBO];

    // Per-lane completed-frame counters, early-eop frames included; wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TURBO; i++) begin
                fcnt_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_TURBO; i++) begin
                if (end_s && (sel_q == PTR_W'(i))) begin
                    fcnt_q[i] <= fcnt_q[i] + 16'd1;
                end else begin
                    fcnt_q[i] <= fcnt_q[i];
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        frame_cnt = {(NUM_TURBO*16){1'b0}};
        for (int i = 0; i < NUM_TURBO; i++) begin
            frame_cnt[16*i +: 16] = fcnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_trb_in_demux.sv
// Self-checking bench for trb_in_demux: directed scenarios plus a randomized phase,
// compared every cycle against a frame-level reference model.
module tb_trb_in_demux;

    localparam int NT = 4;
    localparam int FL = 128;
    localparam int CW = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      din;
    logic            vin, sop_i, eop_i;
    logic [NT-1:0]   rdy;
    logic            st_ready_out;
    logic [NT*8-1:0] dout;
    logic [NT-1:0]   vout, sout, eout;
    logic            err_len, err_sop;
`ifdef TRB_IN_DEMUX_CNT_EN
    logic [NT*16-1:0] fcnt;
`endif

    always #5 clk = ~clk;

    trb_in_demux #(.NUM_TURBO(NT), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .st_data_in(din), .st_valid_in(vin), .st_sop_in(sop_i), .st_eop_in(eop_i),
        .st_ready_out(st_ready_out), .st_data_out(dout), .st_valid_out(vout),
        .st_sop_out(sout), .st_eop_out(eout), .st_ready_in(rdy),
        .err_len(err_len), .err_sop(err_sop)
`ifdef TRB_IN_DEMUX_CNT_EN
        , .frame_cnt(fcnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: whether a frame is open, which lane owns it, how many beats it has,
    // where the round-robin search resumes, and error flags due next cycle.
    bit m_in;
    int m_ptr, m_sel, m_beat;
    bit m_elen, m_esop;
    int m_fcnt[NT];
    bit m_acc;
    bit rand_rdy;
    int d_lanes[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_in = 1'b0; m_ptr = 0; m_sel = 0; m_beat = 0;
        m_elen = 1'b0; m_esop = 1'b0;
        for (int l = 0; l < NT; l++) m_fcnt[l] = 0;
    endtask

    task automatic tick();
        logic            er, acc, first, last, drop, fire, fend;
        logic [NT-1:0]   ev, es, ee;
        logic [NT*8-1:0] ed;
        logic [63:0]     ef;
        if (rand_rdy) rdy = 4'($urandom_range(0, 15));
        #1;
        er    = m_in && rdy[m_sel];
        acc   = vin && er;
        first = (m_beat == 0);
        last  = (m_beat == FL - 1);
        drop  = first && !sop_i;
        fire  = acc && !drop;
        fend  = fire && (last || eop_i);
        ev = '0; es = '0; ee = '0; ed = '0;
        if (m_in) ed[8*m_sel +: 8] = din;
        if (fire) ev[m_sel] = 1'b1;
        if (fire && first) es[m_sel] = 1'b1;
        if (fend) ee[m_sel] = 1'b1;
        chk("ready", st_ready_out, er);
        chk("valid", vout, ev);
        chk("sop", sout, es);
        chk("eop", eout, ee);
        chk("data", dout, ed);
        chk("err_len", err_len, m_elen);
        chk("err_sop", err_sop, m_esop);
`ifdef TRB_IN_DEMUX_CNT_EN
        ef = '0;
        for (int l = 0; l < NT; l++) ef[16*l +: 16] = 16'(m_fcnt[l]);
        chk("frame_cnt", fcnt, ef);
`else
        ef = '0;
`endif
        for (int l = 0; l < NT; l++) if (vout[l] && eout[l]) d_lanes.push_back(l);
        m_acc = acc;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (!m_in) begin
            m_elen = 1'b0; m_esop = 1'b0;
            if (rdy[m_ptr]) begin
                m_sel = m_ptr; m_beat = 0; m_in = 1'b1;
            end else begin
                m_ptr = (m_ptr + 1) % NT;
            end
        end else begin
            m_esop = acc && (first != sop_i);
            m_elen = fire && (last != eop_i);
            if (fend) begin
                m_fcnt[m_sel] = (m_fcnt[m_sel] + 1) % 65536;
                m_in = 1'b0; m_ptr = (m_sel + 1) % NT; m_beat = 0;
            end else if (fire) begin
                m_beat++;
            end
        end
        #1;
    endtask

    task automatic idle(input int k);
        vin = 1'b0;
        repeat (k) begin
            din = 8'($urandom); sop_i = 1'($urandom); eop_i = 1'($urandom);
            tick();
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        din = d; sop_i = s; eop_i = e; vin = 1'b1;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 400);
        if (!m_acc) begin
            checks++; errors++;
            $error("FAIL beat_timeout observed=no_accept expected=accept_within_400");
        end
        vin = 1'b0;
    endtask

    task automatic send_frame(input int n, input int eop_at, input int bad_sop_at,
                              input bit drop_first, input bit gaps,
                              input int stall_beat, input int stall_lane);
        if (drop_first) send_beat(8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (i == stall_beat) begin
                rdy[stall_lane] = 1'b0;
                din = 8'($urandom); sop_i = 1'b0; eop_i = 1'b0; vin = 1'b1;
                repeat (10) tick();
                rdy[stall_lane] = 1'b1;
            end
            send_beat(8'($urandom), (i == 0) || (i == bad_sop_at), i == eop_at);
        end
    endtask

    // exp_seq holds the expected lane order, one nibble per frame starting at the LSB.
    task automatic chk_lanes(input string tag, input logic [31:0] exp_seq, input int n);
        chk({tag, "_count"}, d_lanes.size(), n);
        for (int k = 0; k < n && k < d_lanes.size(); k++)
            chk(tag, d_lanes[k], exp_seq[4*k +: 4]);
        d_lanes.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; vin = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; din = 8'd0; sop_i = 1'b0; eop_i = 1'b0;
        rdy = '1; rand_rdy = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_ready", st_ready_out, 1'b0);
        chk("reset_valid", vout, 4'd0);
        chk("reset_data", dout, 32'd0);
        chk("reset_errs", {err_len, err_sop}, 2'b00);
`ifdef TRB_IN_DEMUX_CNT_EN
        chk("reset_fcnt", fcnt, 64'd0);
`endif

        // Eight back-to-back frames, all lanes ready.
        for (int f = 0; f < 8; f++) send_frame(FL, FL - 1, -1, 1'b0, 1'b0, -1, 0);
        idle(2);
        chk_lanes("rr8", 32'h3210_3210, 8);

        // Only lanes 1 and 3 ready.
        do_reset();
        rdy = 4'b1010;
        for (int f = 0; f < 2; f++) send_frame(FL, FL - 1, -1, 1'b0, 1'b0, -1, 0);
        idle(2);
        chk_lanes("skip", 32'h0000_0031, 2);

        // Lane 2 stalls for 10 cycles at beat 50.
        do_reset();
        rdy = 4'b1111;
        send_frame(FL, FL - 1, -1, 1'b0, 1'b0, -1, 0);
        send_frame(FL, FL - 1, -1, 1'b0, 1'b0, -1, 0);
        send_frame(FL, FL - 1, -1, 1'b0, 1'b1, 50, 2);
        idle(2);
        chk_lanes("stall", 32'h0000_0210, 3);

        // Early eop at beat 99, missing eop, then a normal frame.
        send_frame(100, 99, -1, 1'b0, 1'b0, -1, 0);
        send_frame(FL, -1, -1, 1'b0, 1'b0, -1, 0);
        send_frame(FL, FL - 1, -1, 1'b0, 1'b0, -1, 0);
        idle(2);
        chk_lanes("eop_err", 32'h0000_0103, 3);

        // Missing first sop (dropped beat), then a stray sop at beat 5.
        send_frame(FL, FL - 1, -1, 1'b1, 1'b0, -1, 0);
        send_frame(FL, FL - 1, 5, 1'b0, 1'b0, -1, 0);
        idle(2);
        chk_lanes("sop_err", 32'h0000_0032, 2);

        // Reset in the middle of a lane-1 frame.
        do_reset();
        send_frame(FL, FL - 1, -1, 1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 60; i++) send_beat(8'($urandom), i == 0, 1'b0);
        rst = 1'b1; vin = 1'b1; din = 8'hA5; sop_i = 1'b0; eop_i = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_ready", st_ready_out, 1'b0);
        chk("midrst_valid", vout | sout | eout, 4'd0);
        chk("midrst_data", dout, 32'd0);
        chk("midrst_errs", {err_len, err_sop}, 2'b00);
`ifdef TRB_IN_DEMUX_CNT_EN
        chk("midrst_fcnt", fcnt, 64'd0);
`endif
        vin = 1'b0;
        send_frame(FL, FL - 1, -1, 1'b0, 1'b0, -1, 0);
        idle(2);
        chk_lanes("after_rst", 32'h0000_0000, 2);

        // Randomized phase: ready toggles every cycle, random gaps and framing faults.
        rand_rdy = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int kind, ea;
            kind = $urandom_range(0, 4);
            case (kind)
                2: begin
                    ea = $urandom_range(0, FL - 2);
                    send_frame(ea + 1, ea, -1, 1'b0, 1'b1, -1, 0);
                end
                3: send_frame(FL, -1, -1, 1'b0, 1'b1, -1, 0);
                4: send_frame(FL, FL - 1, $urandom_range(1, FL - 1), 1'b1, 1'b1, -1, 0);
                default: send_frame(FL, FL - 1, -1, 1'b0, 1'b1, -1, 0);
            endcase
        end
        rand_rdy = 1'b0;
        idle(3);
        d_lanes.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
